// File: rtl/full_adder_gate.sv
// One-bit full adder from gate primitives, plus an async-reset registered copy of {C,S}.
// Port order keeps legacy 5-port positional instantiations (S, C, x, y, z) working.
module full_adder_gate (
  output logic S,
  output logic C,
  input  logic x,
  input  logic y,
  input  logic z,
  input  logic clk,
  input  logic rst_n,
  output logic S_q,
  output logic C_q
);

  logic w_t1;
  logic w_a1;
  logic w_a2;
  logic r_s;
  logic r_c;

  xor u_xor_t1 (w_t1, x, y);
  xor u_xor_s  (S, w_t1, z);

  // Carry reuses the half-sum so propagate and generate terms share one XOR.
  and u_and_a1 (w_a1, x, y);
  and u_and_a2 (w_a2, w_t1, z);
  or  u_or_c   (C, w_a1, w_a2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s <= 1'b0;
      r_c <= 1'b0;
    end else begin
      r_s <= S;
      r_c <= C;
    end
  end

  assign S_q = r_s;
  assign C_q = r_c;

endmodule

// File: tb/tb_full_adder_gate.sv
// Directed bench for full_adder_gate: combinational sweep under reset, registered path, async reset.
module tb_full_adder_gate;

  logic S, C, S_q, C_q;
  logic x, y, z;
  logic clk, rst_n;

  int n_assert = 0;
  int n_fail   = 0;

  logic [1:0] exp_cs [8];
  logic [2:0] vec;
  logic       z_unk;
  logic       exp_s_unk;

  full_adder_gate dut (
    .S    (S),
    .C    (C),
    .x    (x),
    .y    (y),
    .z    (z),
    .clk  (clk),
    .rst_n(rst_n),
    .S_q  (S_q),
    .C_q  (C_q)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic clk_pulse();
    clk = 1'b1;
    #5;
    clk = 1'b0;
    #5;
  endtask

  initial begin
    exp_cs[0] = 2'b00; exp_cs[1] = 2'b01; exp_cs[2] = 2'b01; exp_cs[3] = 2'b10;
    exp_cs[4] = 2'b01; exp_cs[5] = 2'b10; exp_cs[6] = 2'b10; exp_cs[7] = 2'b11;

    clk   = 1'b0;
    rst_n = 1'b0;
    x = 1'b0; y = 1'b0; z = 1'b0;

    // Exhaustive sweep with reset held and clock idle.
    for (int i = 0; i < 8; i++) begin
      vec = i[2:0];
      x = vec[2]; y = vec[1]; z = vec[0];
      #1;
      chk($sformatf("sweep%0d_S", i), S, exp_cs[i][0]);
      chk($sformatf("sweep%0d_C", i), C, exp_cs[i][1]);
      chk($sformatf("sweep%0d_Sq", i), S_q, 1'b0);
      chk($sformatf("sweep%0d_Cq", i), C_q, 1'b0);
      #9;
    end

    // Registered path.
    rst_n = 1'b1;
    x = 1'b1; y = 1'b1; z = 1'b1;
    #1;
    chk("pre_edge_Sq", S_q, 1'b0);
    chk("pre_edge_Cq", C_q, 1'b0);
    #4;
    clk_pulse();
    chk("reg111_Sq", S_q, 1'b1);
    chk("reg111_Cq", C_q, 1'b1);

    x = 1'b1; y = 1'b0; z = 1'b0;
    #1;
    chk("noclk100_S", S, 1'b1);
    chk("noclk100_C", C, 1'b0);
    chk("noclk100_Sq", S_q, 1'b1);
    chk("noclk100_Cq", C_q, 1'b1);

    // Async reset between edges.
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_Sq", S_q, 1'b0);
    chk("arst_Cq", C_q, 1'b0);
    chk("arst_S", S, 1'b1);
    chk("arst_C", C, 1'b0);
    #2;
    clk_pulse();
    chk("clk_in_rst_Sq", S_q, 1'b0);
    chk("clk_in_rst_Cq", C_q, 1'b0);

    // Reset release: no capture until the next rising edge.
    x = 1'b0; y = 1'b1; z = 1'b1;
    rst_n = 1'b1;
    #1;
    chk("release_Sq", S_q, 1'b0);
    chk("release_Cq", C_q, 1'b0);
    #4;
    clk_pulse();
    chk("reg011_Sq", S_q, 1'b0);
    chk("reg011_Cq", C_q, 1'b1);

    x = 1'b0; y = 1'b0; z = 1'b1;
    #5;
    clk_pulse();
    chk("reg001_Sq", S_q, 1'b1);
    chk("reg001_Cq", C_q, 1'b0);

    x = 1'b1; y = 1'b1; z = 1'b0;
    #5;
    clk_pulse();
    chk("reg110_Sq", S_q, 1'b0);
    chk("reg110_Cq", C_q, 1'b1);

    // Unknown carry-in: sum follows z, carry is forced 0 by both AND terms.
    z_unk = 1'bx;
    exp_s_unk = 1'b0 ^ 1'b0 ^ z_unk;
    x = 1'b0; y = 1'b0; z = z_unk;
    #1;
    chk("unk_S", S, exp_s_unk);
    chk("unk_C", C, 1'b0);
    #9;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
